// File: rtl/lsu_pkg.sv
// Shared types and helpers for the port-B load/store unit.
// Holds the access-size and FSM encodings, the RAM geometry and the fault/split rules.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BEAT0 = 3'd1,
        ST_BEAT1 = 3'd2,
        ST_DATA  = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    localparam int RAM_WORDS = 16384;
    localparam int RAM_BYTES = 131072;
    localparam int WORD_AW   = 14;

    function automatic logic [2:0] size_bytes(mem_size_e size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

    // An access straddles two 64-bit words when it runs past byte lane 7.
    function automatic logic split_f(logic [2:0] off, mem_size_e size);
        split_f = ({1'b0, off} + {1'b0, size_bytes(size)}) > 4'd8;
    endfunction

    function automatic logic fault_f(logic [31:0] addr, mem_size_e size);
        fault_f = (size == SZ_ILL)
               || (addr >= 32'(RAM_BYTES))
               || (split_f(addr[2:0], size) && (addr[16:3] == WORD_AW'(RAM_WORDS - 1)));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte-enables/data across two beats,
// and load re-alignment with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]   off,
    input  mem_size_e    size,
    input  logic         is_unsigned,
    input  logic [31:0]  wdata,
    input  logic [63:0]  rd_lo,
    input  logic [63:0]  rd_hi,
    output logic [15:0]  mask16,
    output logic [127:0] data128,
    output logic [31:0]  rdata
);

    logic [5:0]  sh;
    logic [3:0]  base;
    logic [31:0] raw;

    always_comb begin
        sh = {off, 3'b000};
        case (size)
            SZ_BYTE: base = 4'h1;
            SZ_HALF: base = 4'h3;
            SZ_WORD: base = 4'hF;
            default: base = 4'h0;
        endcase
        mask16  = {12'd0, base} << off;
        data128 = {96'd0, wdata} << sh;

        raw = 32'({rd_hi, rd_lo} >> sh);
        case (size)
            SZ_BYTE: rdata = is_unsigned ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            SZ_HALF: rdata = is_unsigned ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            SZ_WORD: rdata = raw;
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the 64-bit RAM port B: splits core accesses
// into one or two beats and returns a single-cycle response.
//
// state  | meaning
// IDLE   | ready for a request; a faulting request goes straight to RESP
// BEAT0  | first RAM beat on the bus (word)
// BEAT1  | second beat (word+1) of a split access; load captures beat-0 data
// DATA   | load: capture final RAM data and extend
// RESP   | rsp_valid pulse
module dmem_lsu
    import lsu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [31:0]          rsp_rdata,
    output logic                 ram_en,
    output logic                 ram_ren,
    output logic [7:0]           ram_we,
    output logic [WORD_AW-1:0]   ram_addr,
    output logic [63:0]          ram_din,
    input  logic [63:0]          ram_dout
);

    lsu_state_e state, nstate;

    logic              lat_we, lat_uns, split_q, err_q;
    mem_size_e         lat_size;
    logic [16:0]       lat_addr;
    logic [31:0]       lat_wdata, rdata_q;
    logic [63:0]       beat0_q;

    logic              ram_en_q, ram_ren_q, ram_en_d, ram_ren_d;
    logic [7:0]        ram_we_q, ram_we_d;
    logic [WORD_AW-1:0] ram_addr_q, ram_addr_d;
    logic [63:0]       ram_din_q, ram_din_d;

    logic              accept, req_fault, req_split, idle;
    logic [2:0]        al_off;
    mem_size_e         al_size;
    logic [31:0]       al_wdata, al_rdata;
    logic [63:0]       rd_lo, rd_hi;
    logic [15:0]       mask16;
    logic [127:0]      data128;

    assign idle      = (state == ST_IDLE);
    assign req_ready = idle;
    assign accept    = req_valid & req_ready;
    assign req_fault = fault_f(req_addr, mem_size_e'(req_size));
    assign req_split = split_f(req_addr[2:0], mem_size_e'(req_size));

    // In IDLE the aligner sees the incoming request so beat 0 can be registered on accept.
    assign al_off   = idle ? req_addr[2:0] : lat_addr[2:0];
    assign al_size  = idle ? mem_size_e'(req_size) : lat_size;
    assign al_wdata = idle ? req_wdata : lat_wdata;
    assign rd_lo    = split_q ? beat0_q : ram_dout;
    assign rd_hi    = split_q ? ram_dout : 64'd0;

    lsu_lane_align u_align (
        .off         (al_off),
        .size        (al_size),
        .is_unsigned (lat_uns),
        .wdata       (al_wdata),
        .rd_lo       (rd_lo),
        .rd_hi       (rd_hi),
        .mask16      (mask16),
        .data128     (data128),
        .rdata       (al_rdata)
    );

    always_comb begin
        nstate     = state;
        ram_en_d   = 1'b0;
        ram_ren_d  = 1'b0;
        ram_we_d   = 8'd0;
        ram_addr_d = '0;
        ram_din_d  = 64'd0;
        case (state)
            ST_IDLE:  if (accept) nstate = req_fault ? ST_RESP : ST_BEAT0;
            ST_BEAT0: nstate = split_q ? ST_BEAT1 : (lat_we ? ST_RESP : ST_DATA);
            ST_BEAT1: nstate = lat_we ? ST_RESP : ST_DATA;
            ST_DATA:  nstate = ST_RESP;
            ST_RESP:  nstate = ST_IDLE;
            default:  nstate = ST_IDLE;
        endcase

        if (idle && nstate == ST_BEAT0) begin
            ram_en_d   = 1'b1;
            ram_ren_d  = ~req_we;
            ram_we_d   = req_we ? mask16[7:0] : 8'd0;
            ram_addr_d = req_addr[16:3];
            ram_din_d  = req_we ? data128[63:0] : 64'd0;
        end else if (nstate == ST_BEAT1) begin
            ram_en_d   = 1'b1;
            ram_ren_d  = ~lat_we;
            ram_we_d   = lat_we ? mask16[15:8] : 8'd0;
            ram_addr_d = lat_addr[16:3] + WORD_AW'(1);
            ram_din_d  = lat_we ? data128[127:64] : 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            lat_we     <= 1'b0;
            lat_uns    <= 1'b0;
            lat_size   <= SZ_BYTE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            split_q    <= 1'b0;
            err_q      <= 1'b0;
            beat0_q    <= '0;
            rdata_q    <= '0;
            ram_en_q   <= 1'b0;
            ram_ren_q  <= 1'b0;
            ram_we_q   <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            state      <= nstate;
            ram_en_q   <= ram_en_d;
            ram_ren_q  <= ram_ren_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            if (accept) begin
                lat_we    <= req_we;
                lat_uns   <= req_unsigned;
                lat_size  <= mem_size_e'(req_size);
                lat_addr  <= req_addr[16:0];
                lat_wdata <= req_wdata;
                split_q   <= req_split;
                err_q     <= req_fault;
                rdata_q   <= '0;
            end
            if (state == ST_BEAT1 && !lat_we) beat0_q <= ram_dout;
            if (state == ST_DATA) rdata_q <= al_rdata;
        end
    end

    // Reset masks the strobes immediately so a beat on the bus when reset arrives is never sampled.
    assign ram_en    = ram_en_q & ~rst;
    assign ram_ren   = ram_ren_q & ~rst;
    assign ram_we    = rst ? 8'd0 : ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: directed vectors plus a random run against
// a byte-array model, with a behavioural 64-bit RAM on port B.
module tb_dmem_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_en, ram_ren;
    logic [7:0]  ram_we;
    logic [13:0] ram_addr;
    logic [63:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    dmem_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_ren(ram_ren), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  we;
        logic        ren;
        logic [63:0] din;
    } beat_t;
    beat_t       blog[$];
    logic [63:0] mem[int];

    always @(posedge clk) begin : ram_model
        logic [63:0] cur;
        if (ram_en) begin
            blog.push_back('{ram_addr, ram_we, ram_ren, ram_din});
            cur = mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 64'd0;
            if (ram_ren) ram_dout <= cur;
            for (int b = 0; b < 8; b++)
                if (ram_we[b]) cur[b*8 +: 8] = ram_din[b*8 +: 8];
            mem[int'(ram_addr)] = cur;
        end
    end

    logic [7:0] bm[int];

    function automatic logic [7:0] get_byte(int a);
        return bm.exists(a) ? bm[a] : 8'd0;
    endfunction

    function automatic int nb(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    endfunction

    function automatic logic is_split(logic [31:0] a, logic [1:0] sz);
        return (int'(a[2:0]) + nb(sz)) > 8;
    endfunction

    function automatic logic tb_fault(logic [31:0] a, logic [1:0] sz);
        return (sz == 2'd3) || (a[31:17] != 15'd0) || (is_split(a, sz) && a[16:3] == 14'h3FFF);
    endfunction

    function automatic int tb_lat(logic we, logic [31:0] a, logic [1:0] sz);
        if (tb_fault(a, sz)) return 1;
        if (is_split(a, sz)) return we ? 3 : 4;
        return we ? 2 : 3;
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] sz, logic u);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nb(sz); i++) v[i*8 +: 8] = get_byte(int'(a) + i);
        if (sz == 2'd0) return u ? v : {{24{v[7]}}, v[7:0]};
        if (sz == 2'd1) return u ? v : {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic model_store(logic [31:0] a, logic [1:0] sz, logic [31:0] d);
        for (int i = 0; i < nb(sz); i++) bm[int'(a) + i] = d[i*8 +: 8];
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          c0;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        string       name;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d, expected none", cyc);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_err"}, 64'(rsp_err), 64'(e.err));
                check({e.name, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
                check({e.name, "_lat"}, 64'(cyc - e.c0), 64'(e.lat));
            end
        end
    end

    task automatic issue(logic we, logic [1:0] sz, logic u, logic [31:0] a, logic [31:0] d,
                         logic exp_err, logic [31:0] exp_rdata, int exp_lat, string name);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got req_ready 0, expected 1", name);
            return;
        end
        req_we = we; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        sbq.push_back('{cyc, exp_lat, exp_err, exp_rdata, name});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain(string name);
        int guard = 0;
        while ((sbq.size() != 0 || !req_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain_timeout: got %0d pending, expected 0", name, sbq.size());
        end
    endtask

    initial begin
        int          b0;
        logic [31:0] a, d, er;
        logic [1:0]  sz;
        logic        we, u, f;
        int          sel;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_ram_ctrl", 64'({ram_en, ram_ren, ram_we, ram_addr}), 64'd0);
        check("rst_ram_din", ram_din, 64'd0);
        @(negedge clk) rst = 1'b0;

        // Aligned word store in the upper half of a RAM word, then read back.
        b0 = blog.size();
        issue(1'b1, 2'd2, 1'b0, 32'h0000_0104, 32'hDEADBEEF, 1'b0, 32'd0, 2, "sw_104");
        model_store(32'h104, 2'd2, 32'hDEADBEEF);
        drain("sw_104");
        check("sw_104_beats", 64'(blog.size() - b0), 64'd1);
        check("sw_104_addr", 64'(blog[b0].addr), 64'h020);
        check("sw_104_we", 64'(blog[b0].we), 64'hF0);
        check("sw_104_ren", 64'(blog[b0].ren), 64'd0);
        check("sw_104_din_hi", 64'(blog[b0].din[63:32]), 64'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'd0, 1'b0, 32'hDEADBEEF, 3, "lw_104");
        drain("lw_104");

        // Word store straddling words 1 and 2.
        b0 = blog.size();
        issue(1'b1, 2'd2, 1'b0, 32'h0000_000E, 32'h11223344, 1'b0, 32'd0, 3, "sw_0e");
        model_store(32'h0E, 2'd2, 32'h11223344);
        drain("sw_0e");
        check("sw_0e_beats", 64'(blog.size() - b0), 64'd2);
        check("sw_0e_b0", 64'({blog[b0].addr, blog[b0].we}), 64'({14'd1, 8'hC0}));
        check("sw_0e_b1", 64'({blog[b0+1].addr, blog[b0+1].we}), 64'({14'd2, 8'h03}));
        check("sw_0e_b0_din", blog[b0].din, 64'h3344_0000_0000_0000);
        issue(1'b0, 2'd2, 1'b0, 32'h0000_000E, 32'd0, 1'b0, 32'h11223344, 4, "lw_0e");
        drain("lw_0e");

        // Word 0 = 0x80FF: sign/zero extension.
        issue(1'b1, 2'd1, 1'b0, 32'h0, 32'h0000_80FF, 1'b0, 32'd0, 2, "sh_0");
        model_store(32'h0, 2'd1, 32'h80FF);
        issue(1'b0, 2'd0, 1'b0, 32'h1, 32'd0, 1'b0, 32'hFFFF_FF80, 3, "lb_1");
        issue(1'b0, 2'd0, 1'b1, 32'h1, 32'd0, 1'b0, 32'h0000_0080, 3, "lbu_1");
        issue(1'b0, 2'd1, 1'b0, 32'h0, 32'd0, 1'b0, 32'hFFFF_80FF, 3, "lh_0");
        drain("ext");

        // Faults issue no RAM beat.
        b0 = blog.size();
        issue(1'b0, 2'd2, 1'b0, 32'h0002_0000, 32'd0, 1'b1, 32'd0, 1, "lw_oor");
        issue(1'b0, 2'd1, 1'b0, 32'h0001_FFFF, 32'd0, 1'b1, 32'd0, 1, "lh_top_split");
        issue(1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h1234, 1'b1, 32'd0, 1, "sz_ill");
        drain("faults");
        check("faults_no_beat", 64'(blog.size() - b0), 64'd0);

        // Reset during beat 1 of a split store.
        b0 = blog.size();
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0E; req_wdata = 32'hAABBCCDD; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("rst_b1_ram_en", 64'(ram_en), 64'd0);
        @(posedge clk);
        #1 check("rst_b1_ready", 64'(req_ready), 64'd1);
        @(negedge clk) rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("rst_b1_no_rsp", 64'(rsp_valid), 64'd0);
        end
        check("rst_b1_beats", 64'(blog.size() - b0), 64'd1);
        bm[32'h0E] = 8'hDD;
        bm[32'h0F] = 8'hCC;
        issue(1'b0, 2'd2, 1'b0, 32'h0E, 32'd0, 1'b0, 32'h1122CCDD, 4, "lw_0e_half");
        drain("rst_b1");

        // Random loads/stores in two small windows plus occasional faults.
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 15);
            if (sel < 11)       a = 32'($urandom_range(0, 63));
            else if (sel < 15)  a = 32'h1FFF0 + 32'($urandom_range(0, 15));
            else                a = 32'h0002_0000 + 32'($urandom_range(0, 255));
            sz = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            we = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            d  = $urandom;
            f  = tb_fault(a, sz);
            er = (we || f) ? 32'd0 : model_load(a, sz, u);
            issue(we, sz, u, a, d, f, er, tb_lat(we, a, sz), "rand");
            if (we && !f) model_store(a, sz, d);
        end
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
